// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises key_clk/key_data, deframes 11-bit frames and tracks
// make/break codes. Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_scan_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic [7:0] raw_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] kclk_sync_q;
    logic [SYNC_STAGES-1:0] kdat_sync_q;
    logic                   kclk_prev_q;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [CntW-1:0]        tmo_q, tmo_d;
    logic                   break_q, break_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   pressed_q, pressed_d;
    logic [7:0]             raw_q, raw_d;
    logic                   valid_q;
    logic                   err_q;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic kclk_s, data_s, fall, accept, reject, parity_ok;

    assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
    assign data_s = kdat_sync_q[SYNC_STAGES-1];
    assign fall   = kclk_prev_q & ~kclk_s;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    // Odd parity over the eight data bits plus the parity bit.
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        accept    = 1'b0;
        reject    = 1'b0;
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_s;
`endif
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    if (data_s && parity_ok) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !fall && tmo_q == TmoLast) begin
            state_d = StIdle;
            tmo_d   = '0;
            reject  = 1'b1;
        end
    end

    always_comb begin
        key_code_d = key_code_q;
        pressed_d  = pressed_q;
        break_d    = break_q;
        raw_d      = raw_q;
        err_cnt_d  = err_cnt_q;
        if (reject && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (accept) begin
            raw_d = shift_q;
            if (shift_q == 8'hF0) begin
                break_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                // Extended prefix: the following byte carries the meaning.
                break_d = break_q;
            end else if (break_q) begin
                break_d = 1'b0;
                if (shift_q == key_code_q) begin
                    key_code_d = 8'h00;
                    pressed_d  = 1'b0;
                end
            end else begin
                key_code_d = shift_q;
                pressed_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            kclk_sync_q <= '1;
            kdat_sync_q <= '1;
            kclk_prev_q <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tmo_q       <= '0;
            break_q     <= 1'b0;
            key_code_q  <= 8'h00;
            pressed_q   <= 1'b0;
            raw_q       <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], key_clk};
            kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], key_data};
            kclk_prev_q <= kclk_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            break_q     <= break_d;
            key_code_q  <= key_code_d;
            pressed_q   <= pressed_d;
            raw_q       <= raw_d;
            valid_q     <= accept;
            err_q       <= reject;
            err_cnt_q   <= err_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign key_code    = key_code_q;
    assign key_pressed = pressed_q;
    assign raw_code    = raw_q;
    assign code_valid  = valid_q;
    assign frame_err   = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- PS/2 keyboard front end feeding the CPU's keycode load path (the 8-bit keycode zero-extended onto the register-file load mux).
- Synchronises the raw keyboard clock/data lines into the CPU clock domain and deframes 11-bit PS/2 frames.
- Tracks make/break (0xF0) prefixes and presents a level-held "currently pressed key" code that software polls.
- Also emits a per-byte strobe and an error counter for debug.

Parameters:
- TIMEOUT_CYCLES, 50000: Clk cycles without a key_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop depth of the key_clk/key_data synchronisers (minimum 2).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- key_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- key_data  in  1  raw PS/2 data from the keyboard, asynchronous.
- key_code  out  8  code of the key currently held; 0x00 when none is held.
- key_pressed  out  1  high while key_code is non-zero due to a make code.
- raw_code  out  8  last accepted frame byte, including prefixes.
- code_valid  out  1  one-cycle pulse, registered together with raw_code on each accepted byte.
- frame_err  out  1  one-cycle pulse on any rejected or abandoned frame.
- err_count  out  8  saturating count of frame_err pulses; holds at 0xFF.

Behaviour:
- Reset (synchronous, Rst=1 at posedge):
  - key_code=0x00, key_pressed=0, raw_code=0x00, code_valid=0, frame_err=0, err_count=0.
  - FSM goes to IDLE; bit counter, shift register, timeout counter, break_pending and synchroniser flops all cleared (synchronisers to 1).
  - Rst asserted mid-frame discards the partial frame with no frame_err.
- Synchronisation and edge detection:
  - key_clk and key_data each pass through SYNC_STAGES flops.
  - fall = previous synced key_clk 1 and current 0.
  - All sampling uses synced key_data in the cycle fall is high.
- Frame FSM, acting only on fall:
  - IDLE: data=0 -> DATA, bit count 0. data=1 -> stay IDLE, pulse frame_err.
  - DATA: shift the data bit in LSB-first, entering at bit 7 and shifting right. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: data=1 and parity acceptable -> accept the byte. Otherwise pulse frame_err. Either way -> IDLE.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments each cycle and clears on fall.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE and pulse frame_err.
  - The counter is held at 0 in IDLE.
- Accept latency: raw_code, code_valid, key_code and key_pressed update on the same posedge that ends STOP, i.e. the edge of the cycle in which fall is seen for the stop bit.
- Decode of accepted byte B:
  - B=0xF0: set break_pending; key_code unchanged.
  - B=0xE0: extended prefix consumed, no key_code change; break_pending unchanged.
  - Other B with break_pending=1: clear break_pending. If B equals key_code, set key_code=0x00 and key_pressed=0. Otherwise no change (release of a non-tracked key).
  - Other B with break_pending=0: key_code=B, key_pressed=1. A typematic repeat of the same code leaves the outputs unchanged but still pulses code_valid.
- Simultaneous events: frame_err and code_valid are mutually exclusive by construction. err_count increments on the same edge as frame_err and saturates at 0xFF.
- Keyboard-bound traffic (host-to-device) is not supported; key_clk and key_data are inputs only.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the parity is acceptable only if the 8 data bits plus the parity bit contain an odd number of ones. Otherwise the frame is rejected (frame_err, err_count++, no decode).
- Undefined: the parity bit is sampled and discarded; only start, stop and timeout errors are detected.

Test Plan:
- Make 'A': frame bits 0,0,0,1,1,1,0,0,0,0,1 (start, 0x1C LSB-first, parity 0, stop) at 12 kHz -> one code_valid pulse with raw_code=0x1C, key_code=0x1C, key_pressed=1, err_count=0.
- Release after the make: frames 0xF0 then 0x1C -> two code_valid pulses with raw_code 0xF0 then 0x1C; key_code=0x00 and key_pressed=0 after the second.
- Bad parity (PS2_PARITY_CHECK_EN defined): 0x1C with parity bit 1 -> frame_err pulse, err_count=1, no code_valid, key_code unchanged. Without the macro -> accepted as 0x1C.
- Timeout: start plus 4 data bits, then key_clk held high for TIMEOUT_CYCLES -> frame_err, FSM back in IDLE; the following full 0x32 frame is accepted correctly (key_code=0x32).
- Reset mid-frame: Rst pulsed for 1 cycle after 5 data bits of 0x1C, keyboard restarts with full 0x2B -> all outputs 0 after reset, frame_err never pulses, key_code=0x2B.
- Extended/foreign release: make 0x1C, then E0, F0, 0x74 -> key_code stays 0x1C; then 255 start-bit-1 glitches -> err_count saturates at 0xFF.
